// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Multiplies by radix-2 shift-add and divides by restoring division. Both work
// on operand magnitudes, and the sign is corrected in a final cycle. A normal
// operation takes WIDTH iterations plus one finalize cycle, then raises done
// for one cycle.
//
// Optional feature: define MULDIV_FAST_SPECIAL_EN to finish divide-by-zero and
// signed-overflow divides after a single CALC cycle. The result is the same;
// only the latency changes.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   start     request, sampled in IDLE or DONE
//   funct3    M-extension operation select
//   rs1_data  operand A (multiplicand / dividend)
//   rs2_data  operand B (multiplier / divisor)
//   rd_in     destination index, captured with start
//   busy      operation in progress
//   done      one-cycle result-valid pulse (register-file write enable)
//   result    computed value, held until the next result
//   rd_out    captured destination index
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam bit FastSpecial = 1'b1;
`else
  localparam bit FastSpecial = 1'b0;
`endif

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;       // original operand A, for special-case results
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier shifting out / quotient shifting in
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rd_q, rd_d;

  // Operand decode at capture time
  logic             accept;
  logic             in_sgn_a, in_sgn_b, in_neg_a, in_neg_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  always_comb begin
    accept   = start && (state_q != StCalc);
    in_sgn_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    in_sgn_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    in_neg_a = in_sgn_a && rs1_data[WIDTH-1];
    in_neg_b = in_sgn_b && rs2_data[WIDTH-1];
    in_mag_a = in_neg_a ? (WIDTH'(0) - rs1_data) : rs1_data;
    in_mag_b = in_neg_b ? (WIDTH'(0) - rs2_data) : rs2_data;
  end

  // One iteration of each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
  end

  // Sign correction and special-case override
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, final_val;

  always_comb begin
    prod     = {acc_q, lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? ((2*WIDTH)'(0) - prod) : prod;
    quot_fix = (neg_a_q ^ neg_b_q) ? (WIDTH'(0) - lo_q) : lo_q;
    rem_fix  = neg_a_q ? (WIDTH'(0) - acc_q) : acc_q;
    case (op_q)
      3'd0:    final_val = prod_fix[WIDTH-1:0];
      3'd1,
      3'd2,
      3'd3:    final_val = prod_fix[2*WIDTH-1:WIDTH];
      3'd4:    final_val = quot_fix;
      3'd5:    final_val = lo_q;
      3'd6:    final_val = rem_fix;
      default: final_val = acc_q;
    endcase
    // op_q[1] separates remainder from quotient among the divide ops
    if (div_zero_q) begin
      final_val = op_q[1] ? a_q : {WIDTH{1'b1}};
    end else if (ovf_q) begin
      final_val = op_q[1] ? {WIDTH{1'b0}} : a_q;
    end
  end

  // Next-state logic
  logic finish;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    rd_d       = rd_q;
    finish     = (cnt_q == LastCnt) || (FastSpecial && (div_zero_q || ovf_q));

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d    = StCalc;
          cnt_d      = '0;
          op_d       = funct3;
          a_d        = rs1_data;
          neg_a_d    = in_neg_a;
          neg_b_d    = in_neg_b;
          acc_d      = '0;
          rd_d       = rd_in;
          div_zero_d = funct3[2] && (rs2_data == '0);
          ovf_d      = (funct3 == 3'd4 || funct3 == 3'd6) && (rs1_data == MinNeg) &&
                       (rs2_data == {WIDTH{1'b1}});
          if (funct3[2]) begin
            lo_d  = in_mag_a;
            opb_d = in_mag_b;
          end else begin
            lo_d  = in_mag_b;
            opb_d = in_mag_a;
          end
        end
      end
      StCalc: begin
        if (finish) begin
          result_d = final_val;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            // Restore when the trial subtraction goes negative
            acc_d = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
          end else begin
            acc_d = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      lo_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      lo_q       <= lo_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
    end
  end

  assign busy   = (state_q == StCalc);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 33;
`endif
  localparam int NormLat = 33;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done, starting just after the capture edge E0.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat,
                           input logic [31:0] exp_res, input logic [4:0] exp_rd);
    int lat;
    bit busy_ok;
    lat     = lat0;
    busy_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    check({tag, " result"}, result, exp_res);
    check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, exp_rd});
  endtask

  // Called #1 after an edge; returns #1 after the edge where done rose.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                        input logic [31:0] exp_res);
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rs1_data = 32'hDEAD_BEEF;  // operands only need to be valid at the capture edge
    rs2_data = 32'h0BAD_F00D;
    rd_in    = 5'd31;
    check({tag, " busy after E0"}, {31'd0, busy}, 32'd1);
    wait_done(tag, 0, exp_lat, exp_res, rd);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = '0;
    rs2_data = '0;
    rd_in    = '0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, NormLat, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    check("done one cycle", {31'd0, done}, 32'd0);

    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, NormLat, 32'h4000_0000);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, NormLat, 32'hFFFF_FFFE);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, NormLat, 32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, NormLat, 32'hFFFF_FFFD);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, NormLat, 32'hFFFF_FFFF);
    run_op("divu",   3'd5, 32'd100, 32'd7, 5'd7, NormLat, 32'd14);
    run_op("remu",   3'd7, 32'd100, 32'd7, 5'd8, NormLat, 32'd2);
    run_op("divu0",  3'd5, 32'h1234, 32'd0, 5'd10, SpecLat, 32'hFFFF_FFFF);
    run_op("remu0",  3'd7, 32'h1234, 32'd0, 5'd11, SpecLat, 32'h0000_1234);
    run_op("div0",   3'd4, 32'hFFFF_FFF9, 32'd0, 5'd12, SpecLat, 32'hFFFF_FFFF);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, SpecLat, 32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, SpecLat, 32'h0000_0000);
    @(posedge clk);
    #1;

    // start during CALC must be ignored
    funct3   = 3'd0;
    rs1_data = 32'd3;
    rs2_data = 32'd5;
    rd_in    = 5'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    funct3   = 3'd5;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_in    = 5'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 6, NormLat, 32'd15, 5'd1);

    // Back-to-back: new start issued in the DONE cycle
    run_op("b2b", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, NormLat, 32'hFFFF_FFFE);

    // Reset asserted at iteration 10 of a DIV
    funct3   = 3'd4;
    rs1_data = 32'd1000;
    rs2_data = 32'd7;
    rd_in    = 5'd20;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort rd_out", {27'd0, rd_out}, 32'd0);
    #2;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("idle after abort", {30'd0, busy, done}, 32'd0);
    end
    run_op("mul after reset", 3'd0, 32'd3, 32'd4, 5'd14, NormLat, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
